// File: rtl/accel_job_sched.sv
// accel_job_sched: job FIFO, validation and start/done/timeout supervision for the byte-increment accelerator.
// Optional performance counters are compiled in when ACC_SCHED_PERF_EN is defined.
package accel_pkg;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUNNING = 1'b1} acc_state_t;
endpackage

module accel_job_sched
  import accel_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CYC_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [3:0]                    push_tag,
  input  logic [7:0]                    push_max_cnt,
  input  logic [7:0]                    push_incr,
  input  logic                          flush,
  output logic                          acc_start,
  output logic [7:0]                    acc_max_cnt,
  output logic [7:0]                    acc_incr,
  input  logic                          acc_done,
  input  acc_state_t                    acc_state,
  output logic                          cmpl_valid,
  input  logic                          cmpl_ready,
  output logic [3:0]                    cmpl_tag,
  output logic [1:0]                    cmpl_status,
  output logic [CYC_WIDTH-1:0]          cmpl_cycles,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   jobs_pending
`ifdef ACC_SCHED_PERF_EN
  ,
  output logic [15:0]                   perf_jobs_ok,
  output logic [15:0]                   perf_jobs_err,
  output logic [31:0]                   perf_busy_cycles
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_INVALID = 2'd1;
  localparam logic [1:0] STAT_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_WAIT_IDLE, S_REPORT} state_t;

  state_t            state_r, state_nxt_s;
  logic [19:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [PW:0]       count_r;
  logic              full_s, push_s, pop_s;
  logic [19:0]       head_s;
  logic              head_invalid_s, timeout_s;
  logic [CYC_WIDTH-1:0] cyc_cnt_r, cyc_inc_s;
  logic [TW-1:0]     tmo_cnt_r;
  logic [3:0]        tag_r;
  logic [1:0]        status_r;
  logic [7:0]        max_cnt_r, incr_r;

  assign full_s         = (count_r == (PW+1)'(FIFO_DEPTH));
  assign push_ready     = !full_s && !flush && !rst;
  assign push_s         = push_valid && push_ready;
  assign head_s         = fifo_mem_r[rd_ptr_r];
  assign head_invalid_s = head_s[8] || (head_s[15:8] == 8'd0);
  assign timeout_s      = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign cyc_inc_s      = (&cyc_cnt_r) ? cyc_cnt_r : cyc_cnt_r + CYC_WIDTH'(1);

  assign acc_start    = (state_r == S_LAUNCH);
  assign cmpl_valid   = (state_r == S_REPORT);
  assign busy         = (state_r != S_IDLE) || (count_r != (PW+1)'(0));
  assign jobs_pending = count_r;
  assign acc_max_cnt  = max_cnt_r;
  assign acc_incr     = incr_r;
  assign cmpl_tag     = tag_r;
  assign cmpl_status  = status_r;
  assign cmpl_cycles  = cyc_cnt_r;

  // Job storage; data needs no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= {push_tag, push_max_cnt, push_incr};
  end

  // Queue pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state and pop decision; done outside RUN/WAIT_IDLE is ignored.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if ((count_r != (PW+1)'(0)) && !flush && !cmpl_valid) begin
          pop_s       = 1'b1;
          state_nxt_s = head_invalid_s ? S_REPORT : S_LAUNCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LAUNCH: state_nxt_s = S_RUN;
      S_RUN: begin
        if (acc_done)       state_nxt_s = S_REPORT;
        else if (timeout_s) state_nxt_s = S_WAIT_IDLE;
        else                state_nxt_s = S_RUN;
      end
      S_WAIT_IDLE: begin
        if (acc_done || (acc_state == ST_IDLE)) state_nxt_s = S_REPORT;
        else                                    state_nxt_s = S_WAIT_IDLE;
      end
      S_REPORT: begin
        if (cmpl_ready) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_REPORT;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Job registers, cycle/timeout counters and the completion record.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_r     <= 4'd0;
      max_cnt_r <= 8'd0;
      incr_r    <= 8'd0;
      status_r  <= STAT_OK;
      cyc_cnt_r <= CYC_WIDTH'(0);
      tmo_cnt_r <= TW'(0);
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            tag_r     <= head_s[19:16];
            max_cnt_r <= head_s[15:8];
            incr_r    <= head_s[7:0];
            cyc_cnt_r <= CYC_WIDTH'(0);
            status_r  <= head_invalid_s ? STAT_INVALID : STAT_OK;
          end
        end
        S_LAUNCH: begin
          cyc_cnt_r <= CYC_WIDTH'(0);
          tmo_cnt_r <= TW'(0);
        end
        S_RUN: begin
          cyc_cnt_r <= cyc_inc_s;
          tmo_cnt_r <= tmo_cnt_r + TW'(1);
          if (acc_done)       status_r <= STAT_OK;
          else if (timeout_s) status_r <= STAT_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

`ifdef ACC_SCHED_PERF_EN
  // Wrapping performance counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs_ok     <= 16'd0;
      perf_jobs_err    <= 16'd0;
      perf_busy_cycles <= 32'd0;
    end else begin
      if (cmpl_valid && cmpl_ready) begin
        if (status_r == STAT_OK) perf_jobs_ok  <= perf_jobs_ok + 16'd1;
        else                     perf_jobs_err <= perf_jobs_err + 16'd1;
      end
      if (busy) perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_accel_job_sched.sv
// Bench for accel_job_sched: accelerator model plus a job-queue reference; directed steps then random jobs.
module tb_accel_job_sched;
  import accel_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst, push_valid, push_ready, flush, acc_start, acc_done, cmpl_valid, cmpl_ready, busy;
  logic [3:0] push_tag, cmpl_tag;
  logic [7:0] push_max_cnt, push_incr, acc_max_cnt, acc_incr;
  logic [1:0] cmpl_status;
  logic [CW-1:0] cmpl_cycles;
  logic [2:0] jobs_pending;
  acc_state_t acc_state;
`ifdef ACC_SCHED_PERF_EN
  logic [15:0] perf_jobs_ok, perf_jobs_err;
  logic [31:0] perf_busy_cycles;
`endif

  accel_job_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .CYC_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_tag(push_tag), .push_max_cnt(push_max_cnt), .push_incr(push_incr), .flush(flush),
    .acc_start(acc_start), .acc_max_cnt(acc_max_cnt), .acc_incr(acc_incr),
    .acc_done(acc_done), .acc_state(acc_state), .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
    .cmpl_tag(cmpl_tag), .cmpl_status(cmpl_status), .cmpl_cycles(cmpl_cycles),
    .busy(busy), .jobs_pending(jobs_pending)
`ifdef ACC_SCHED_PERF_EN
    , .perf_jobs_ok(perf_jobs_ok), .perf_jobs_err(perf_jobs_err), .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Accelerator model: done on the Nth cycle after the start pulse; optionally hangs.
  logic       m_run = 1'b0;
  logic [7:0] m_rem = 8'd0;
  logic       hang, release_idle, spur;
  always @(posedge clk) begin
    if (acc_start) begin
      m_run <= 1'b1;
      m_rem <= acc_max_cnt;
    end else if (m_run) begin
      if (hang) begin
        if (release_idle) m_run <= 1'b0;
      end else if (m_rem == 8'd1) m_run <= 1'b0;
      else m_rem <= m_rem - 8'd1;
    end
  end
  assign acc_done  = (m_run && !hang && m_rem == 8'd1) || spur;
  assign acc_state = m_run ? ST_RUNNING : ST_IDLE;

  typedef struct packed {
    logic [3:0] tag; logic [7:0] max; logic [7:0] incr; logic [1:0] st; logic [15:0] cyc;
  } job_t;
  job_t exp_q[$];

  int checks = 0, failures = 0, starts = 0, n_ok = 0, n_err = 0, s0;
  bit prev_start = 0, push_acc = 0, rnd_ready = 0, exp_hang = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected record of a job, derived from the job fields alone.
  function automatic job_t mk(input logic [3:0] t, input logic [7:0] m, input logic [7:0] i, input bit hg);
    job_t j;
    j.tag = t; j.max = m; j.incr = i;
    if (m == 8'd0 || (m % 2) == 1) begin j.st = 2'd1; j.cyc = 16'd0; end
    else if (hg) begin j.st = 2'd2; j.cyc = 16'(TMO); end
    else begin j.st = 2'd0; j.cyc = 16'(m); end
    return j;
  endfunction

  // One clock: score handshakes/starts seen this cycle, then advance.
  task automatic cyc();
    job_t e;
    #2;
    if (cmpl_valid && cmpl_ready) begin
      chk("rec_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rec_tag", cmpl_tag, e.tag);
        chk("rec_status", cmpl_status, e.st);
        chk("rec_cycles", cmpl_cycles, e.cyc);
        if (e.st != 2'd1) chk("cfg_hold", {acc_max_cnt, acc_incr}, {e.max, e.incr});
        if (e.st == 2'd0) n_ok++; else n_err++;
      end
    end
    if (acc_start) begin
      starts++;
      chk("start_single", prev_start, 0);
      chk("start_has_job", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("start_cfg", {acc_max_cnt, acc_incr}, {exp_q[0].max, exp_q[0].incr});
    end
    prev_start = acc_start;
    push_acc = 0;
    if (push_valid && push_ready) begin
      push_acc = 1;
      exp_q.push_back(mk(push_tag, push_max_cnt, push_incr, exp_hang));
    end
    @(posedge clk); #1;
    if (rnd_ready) cmpl_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_job(input logic [3:0] t, input logic [7:0] m, input logic [7:0] i);
    bit ok = 0;
    push_valid = 1'b1; push_tag = t; push_max_cnt = m; push_incr = i;
    for (int k = 0; k < 300 && !ok; k++) begin
      cyc();
      ok = push_acc;
    end
    push_valid = 1'b0;
    chk("push_accepted", ok, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && (exp_q.size() != 0 || busy); k++) cyc();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", busy, 0);
  endtask

  task automatic chk_reset();
    chk("rst_start", acc_start, 0);
    chk("rst_cfg", {acc_max_cnt, acc_incr}, 0);
    chk("rst_cmpl_valid", cmpl_valid, 0);
    chk("rst_record", {cmpl_tag, cmpl_status, cmpl_cycles}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", jobs_pending, 0);
    chk("rst_push_ready", push_ready, 0);
`ifdef ACC_SCHED_PERF_EN
    chk("rst_perf", {perf_jobs_ok, perf_jobs_err} | perf_busy_cycles, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; push_valid = 1'b0; push_tag = 4'd0; push_max_cnt = 8'd0; push_incr = 8'd0;
    flush = 1'b0; cmpl_ready = 1'b1; hang = 1'b0; release_idle = 1'b0; spur = 1'b0;
    repeat (3) cyc();
    chk_reset();
    rst = 1'b0;
    cyc();

    // Nominal job: one start, 8 RUN cycles.
    s0 = starts;
    push_job(4'd3, 8'd8, 8'd1);
    drain();
    chk("nominal_starts", starts, s0 + 1);

    // Invalid configs: no start, reported in order.
    s0 = starts;
    push_job(4'd1, 8'd5, 8'd2);
    push_job(4'd2, 8'd0, 8'd2);
    drain();
    chk("invalid_starts", starts, s0);

    // Fill the queue while the first record is held.
    cmpl_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) push_job(4'(k + 4), 8'(2 * (k + 1)), 8'(k));
    repeat (20) cyc();
    chk("full_pending", jobs_pending, DEPTH);
    push_valid = 1'b1; push_tag = 4'd15; push_max_cnt = 8'd2; #1;
    chk("full_ready", push_ready, 0);
    cyc();
    chk("full_ready_hold", push_ready, 0);
    push_valid = 1'b0;
    cmpl_ready = 1'b1;
    drain();

    // Timeout: accelerator never finishes; next job held until it goes idle.
    s0 = starts;
    hang = 1'b1; exp_hang = 1;
    push_job(4'd9, 8'd8, 8'd3);
    repeat (30) cyc();
    chk("tmo_no_record", cmpl_valid, 0);
    chk("tmo_busy", busy, 1);
    exp_hang = 0;
    push_job(4'd10, 8'd4, 8'd7);
    repeat (5) cyc();
    chk("tmo_no_restart", starts, s0 + 1);
    release_idle = 1'b1;
    cyc();
    release_idle = 1'b0; hang = 1'b0;
    drain();
    chk("tmo_starts", starts, s0 + 2);

    // Flush during the first job's RUN.
    s0 = starts;
    push_job(4'd11, 8'd14, 8'd1);
    push_job(4'd12, 8'd14, 8'd1);
    push_job(4'd13, 8'd14, 8'd1);
    for (int k = 0; k < 20 && starts == s0; k++) cyc();
    repeat (2) cyc();
    chk("flush_pending_before", jobs_pending, 2);
    flush = 1'b1; push_valid = 1'b1; push_tag = 4'd14; push_max_cnt = 8'd2; #1;
    chk("flush_push_ready", push_ready, 0);
    cyc();
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    flush = 1'b0; push_valid = 1'b0;
    chk("flush_pending_after", jobs_pending, 0);
    drain();
    chk("flush_starts", starts, s0 + 1);

    // Spurious done while idle is ignored.
    spur = 1'b1; cyc(); spur = 1'b0; cyc();
    chk("spur_no_record", cmpl_valid, 0);
    chk("spur_idle", busy, 0);

    // Random jobs with random completion back-pressure.
    rnd_ready = 1;
    for (int n = 0; n < 30; n++) begin
      push_job(4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom));
      repeat ($urandom_range(0, 3)) cyc();
    end
    rnd_ready = 0; cmpl_ready = 1'b1;
    drain();
`ifdef ACC_SCHED_PERF_EN
    chk("perf_ok", perf_jobs_ok, n_ok);
    chk("perf_err", perf_jobs_err, n_err);
`endif

    // Reset in RUN abandons the job.
    s0 = starts;
    push_job(4'd6, 8'd14, 8'd5);
    for (int k = 0; k < 20 && starts == s0; k++) cyc();
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    exp_q.delete();
    chk_reset();
    rst = 1'b0;
    repeat (20) cyc();
    chk("post_rst_no_record", cmpl_valid, 0);
    chk("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
